sum_ctrl: RTL

- FSM controller for the dedicated "sum 1..N" processor on Basys3.
- Sequences an external datapath: index register I, accumulator register SUM, comparator (I <= N), and output buffer.
- Adds a start/busy/done handshake, a step-pacing input, abort, and an iteration watchdog.
- The top-level wrapper drives it; the datapath returns only the comparator flag.

---
 rtl/sum_ctrl_if.sv | 30 +++
 rtl/sum_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/sum_ctrl_if.sv
// Control bundle between the sum_ctrl sequencer and its wrapper/datapath.
// Handshake: iStart is honoured only while oBusy=0 (IDLE or ERR); the run ends with a
// one-cycle oDone pulse, an oErr level (watchdog), or an abort back to IDLE with no oDone.
interface sum_ctrl_if;
   logic       iStart;
   logic       iAbort;
   logic       iStep;
   logic       iILeN;
   logic       oISrcSel;
   logic       oILoad;
   logic       oSumSrcSel;
   logic       oSumLoad;
   logic       oOutBufSel;
   logic       oBusy;
   logic       oDone;
   logic       oErr;
   logic [2:0] dbgState;

   modport master (
      output iStart, iAbort, iStep, iILeN,
      input  oISrcSel, oILoad, oSumSrcSel, oSumLoad, oOutBufSel,
      input  oBusy, oDone, oErr, dbgState
   );

   modport slave (
      input  iStart, iAbort, iStep, iILeN,
      output oISrcSel, oILoad, oSumSrcSel, oSumLoad, oOutBufSel,
      output oBusy, oDone, oErr, dbgState
   );
endinterface

// File: rtl/sum_ctrl.sv
// Moore sequencer for the "sum 1..N" datapath with pacing, abort and an iteration watchdog.
// Optional macro SUM_CTRL_RUNNING_OUT_EN: also load the output buffer in INC (running sum).
module sum_ctrl #(
   parameter int MAX_ITER = 255
) (
   input  logic       iClk,
   input  logic       iRst_n,
   sum_ctrl_if.slave  bus
);
   localparam int ITER_W = $clog2(MAX_ITER + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      CMP  = 3'd2,
      ADD  = 3'd3,
      INC  = 3'd4,
      DONE = 3'd5,
      ERR  = 3'd6
   } state_t;

   state_t            state;
   state_t            stateNext;
   logic [ITER_W-1:0] iterCnt;
   logic [ITER_W-1:0] iterCntNext;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state   <= IDLE;
         iterCnt <= '0;
      end else begin
         state   <= stateNext;
         iterCnt <= iterCntNext;
      end
   end

   always_comb begin
      stateNext   = state;
      iterCntNext = iterCnt;
      case (state)
         IDLE: if (bus.iStart) stateNext = INIT;
         INIT: begin
            iterCntNext = '0;
            stateNext   = CMP;
         end
         CMP: begin
            // Watchdog is checked before ADD so the counter can never pass MAX_ITER.
            if (bus.iStep) begin
               if (!bus.iILeN)                          stateNext = DONE;
               else if (iterCnt == ITER_W'(MAX_ITER))   stateNext = ERR;
               else                                     stateNext = ADD;
            end
         end
         ADD: stateNext = INC;
         INC: begin
            iterCntNext = iterCnt + 1'b1;
            stateNext   = CMP;
         end
         DONE: stateNext = IDLE;
         ERR: begin
            if (bus.iStart) begin
               iterCntNext = '0;
               stateNext   = INIT;
            end
         end
         default: stateNext = IDLE;
      endcase
      if (bus.iAbort && (state != IDLE) && (state != ERR)) stateNext = IDLE;
   end

   always_comb begin
      bus.oISrcSel   = 1'b0;
      bus.oILoad     = 1'b0;
      bus.oSumSrcSel = 1'b0;
      bus.oSumLoad   = 1'b0;
      bus.oOutBufSel = 1'b0;
      bus.oBusy      = 1'b0;
      bus.oDone      = 1'b0;
      bus.oErr       = 1'b0;
      case (state)
         INIT: begin
            bus.oILoad   = 1'b1;
            bus.oSumLoad = 1'b1;
            bus.oBusy    = 1'b1;
         end
         CMP: bus.oBusy = 1'b1;
         ADD: begin
            bus.oSumSrcSel = 1'b1;
            bus.oSumLoad   = 1'b1;
            bus.oBusy      = 1'b1;
         end
         INC: begin
            bus.oISrcSel = 1'b1;
            bus.oILoad   = 1'b1;
            bus.oBusy    = 1'b1;
`ifdef SUM_CTRL_RUNNING_OUT_EN
            bus.oOutBufSel = 1'b1;
`else
            bus.oOutBufSel = 1'b0;
`endif
         end
         DONE: begin
            bus.oOutBufSel = 1'b1;
            bus.oBusy      = 1'b1;
            bus.oDone      = 1'b1;
         end
         ERR: bus.oErr = 1'b1;
         default: ;
      endcase
   end

   assign bus.dbgState = state;
endmodule
